// File: rtl/ram_sdp_sync_clr.sv
// ram_sdp_sync_clr
//   Single-clock simple-dual-port RAM with one write port and one read port.
//   - Read latency is selectable: READ_LATENCY = 1 or 2.
//   - q_valid is a one-cycle strobe for each accepted read.
//   - A read and a write to the same address in the same cycle is write-first.
//   - After every reset, a clear sequencer writes CLEAR_VALUE to every word.
//     The ports are ignored while busy is high.
//   Optional feature: define RAM_PARITY_EN to store an even-parity bit per word.
//   parity_err then flags a mismatch on the word being delivered.

module ram_sdp_sync_clr #(
   parameter int                    DATA_WIDTH   = 8,
   parameter int                    ADDR_WIDTH   = 6,
   parameter int                    READ_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  q_valid,
   output logic                  busy,
   output logic                  parity_err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef RAM_PARITY_EN
   localparam int MEM_W = DATA_WIDTH + 1;
`else
   localparam int MEM_W = DATA_WIDTH;
`endif

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Build a stored word from a data value. With parity enabled, the top bit holds even parity.
   function automatic logic [MEM_W-1:0] make_word(input logic [DATA_WIDTH-1:0] d);
`ifdef RAM_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   logic [MEM_W-1:0] mem [DEPTH];

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
   logic                  busy_q, busy_d;

   logic                  ready_s;
   logic                  mem_we_s;
   logic [ADDR_WIDTH-1:0] mem_waddr_s;
   logic [MEM_W-1:0]      mem_wdata_s;
   logic                  rd_acc_s;
   logic [MEM_W-1:0]      rd_word_s;
   logic [MEM_W-1:0]      out_word_s;
   logic                  out_vld_s;

   logic [DATA_WIDTH-1:0] q_q, q_d;
   logic                  q_valid_q, q_valid_d;

   assign ready_s = (state_q == ST_READY);

   // Clear sequencer next state: walk every address once, then settle in READY until reset.
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         ST_CLEAR: begin
            clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
            if (clr_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
               state_d = ST_READY;
            end else begin
               state_d = ST_CLEAR;
            end
         end
         ST_READY: begin
            state_d = ST_READY;
         end
         default: begin
            state_d    = ST_CLEAR;
            clr_addr_d = '0;
         end
      endcase
      busy_d = (state_d == ST_CLEAR);
   end

   // Sequencer registers. Reset always restarts the clear from address 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         busy_q     <= busy_d;
      end
   end

   // Select the write source: the clear sequencer while clearing, the user port once ready.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_waddr_s = write_addr;
      mem_wdata_s = make_word(data);
      if (reset) begin
         mem_we_s = 1'b0;
      end else if (!ready_s) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = clr_addr_q;
         mem_wdata_s = make_word(CLEAR_VALUE);
      end else begin
         mem_we_s = we;
      end
   end

   // Storage array write port. There is no reset; the sequencer initialises the contents.
   always_ff @(posedge clock) begin
      if (mem_we_s) begin
         mem[mem_waddr_s] <= mem_wdata_s;
      end
   end

   // Array read with write-first bypass when the same address is written in this cycle.
   always_comb begin
      rd_acc_s = re && ready_s;
      if (we && ready_s && (write_addr == read_addr)) begin
         rd_word_s = make_word(data);
      end else begin
         rd_word_s = mem[read_addr];
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic [MEM_W-1:0] s1_word_q;
         logic             s1_vld_q;

         // Extra pipeline stage between the array read and the output register.
         always_ff @(posedge clock) begin
            if (reset) begin
               s1_word_q <= '0;
               s1_vld_q  <= 1'b0;
            end else begin
               s1_word_q <= rd_word_s;
               s1_vld_q  <= rd_acc_s;
            end
         end

         assign out_word_s = s1_word_q;
         assign out_vld_s  = s1_vld_q;
      end else begin : g_lat1
         assign out_word_s = rd_word_s;
         assign out_vld_s  = rd_acc_s;
      end
   endgenerate

   // Output stage next values: load q on a valid read, otherwise hold it.
   always_comb begin
      q_d       = q_q;
      q_valid_d = 1'b0;
      if (out_vld_s) begin
         q_d       = out_word_s[DATA_WIDTH-1:0];
         q_valid_d = 1'b1;
      end else begin
         q_d       = q_q;
         q_valid_d = 1'b0;
      end
   end

   // Output registers. Reset flushes them so no stale read survives.
   always_ff @(posedge clock) begin
      if (reset) begin
         q_q       <= '0;
         q_valid_q <= 1'b0;
      end else begin
         q_q       <= q_d;
         q_valid_q <= q_valid_d;
      end
   end

`ifdef RAM_PARITY_EN
   logic perr_q, perr_d;

   // Compare the stored parity bit with parity recomputed from the delivered data.
   always_comb begin
      perr_d = 1'b0;
      if (out_vld_s) begin
         perr_d = out_word_s[DATA_WIDTH] ^ (^out_word_s[DATA_WIDTH-1:0]);
      end else begin
         perr_d = 1'b0;
      end
   end

   // Parity error flag register, aligned with q_valid.
   always_ff @(posedge clock) begin
      if (reset) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
      end
   end

   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

   assign q       = q_q;
   assign q_valid = q_valid_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_ram_sdp_sync_clr.sv
// Directed testbench for ram_sdp_sync_clr.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ram_sdp_sync_clr #(
   parameter int LAT = 1
);

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       we = 1'b0;
   logic [5:0] write_addr = 6'd0;
   logic [7:0] data = 8'h00;
   logic       re = 1'b0;
   logic [5:0] read_addr = 6'd0;
   logic [7:0] q;
   logic       q_valid;
   logic       busy;
   logic       parity_err;

   int vectors = 0;
   int errors  = 0;

   ram_sdp_sync_clr #(
      .DATA_WIDTH(8), .ADDR_WIDTH(6), .READ_LATENCY(LAT), .CLEAR_VALUE(8'h00)
   ) dut (
      .clock(clock), .reset(reset), .we(we), .write_addr(write_addr), .data(data),
      .re(re), .read_addr(read_addr), .q(q), .q_valid(q_valid), .busy(busy),
      .parity_err(parity_err)
   );

   always #5 clock = ~clock;

   // X on the enables outside reset is illegal
   always @(posedge clock) begin
      if (!reset) begin
         assert (!$isunknown({we, re})) else $error("X on we/re");
      end
   end

   // Issue one read and wait until its result is due at the sampling point
   task automatic do_read(input logic [5:0] a);
      re = 1'b1; read_addr = a;
      @(negedge clock);
      re = 1'b0;
      repeat (LAT - 1) @(negedge clock);
   endtask

   task automatic do_write(input logic [5:0] a, input logic [7:0] d);
      we = 1'b1; write_addr = a; data = d;
      @(negedge clock);
      we = 1'b0;
   endtask

   // Count busy cycles after release, bounded so a stuck busy cannot hang the run
   task automatic wait_clear(output int cnt);
      cnt = 0;
      while (busy === 1'b1 && cnt < 200) begin
         @(negedge clock);
         cnt++;
      end
   endtask

   task automatic test_reset;
      int cnt;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      vectors++;
      if (busy !== 1'b1 || q !== 8'h00 || q_valid !== 1'b0 || parity_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: busy=%b q=%h q_valid=%b perr=%b, expected 1 00 0 0",
                  busy, q, q_valid, parity_err);
      end
      reset = 1'b0;
      wait_clear(cnt);
      vectors++;
      if (cnt != 64) begin
         errors++;
         $display("FAIL busy_length: got %0d cycles, expected 64", cnt);
      end
   endtask

   task automatic test_clear_readback;
      int bad = 0;
      for (int i = 0; i < 64 + LAT; i++) begin
         if (i >= LAT) begin
            if (q_valid !== 1'b1 || q !== 8'h00 || parity_err !== 1'b0) bad++;
         end
         if (i < 64) begin
            re = 1'b1; read_addr = 6'(i);
         end else begin
            re = 1'b0;
         end
         @(negedge clock);
      end
      vectors++;
      if (bad != 0) begin
         errors++;
         $display("FAIL clear_readback: %0d bad reads, expected 0", bad);
      end
      vectors++;
      if (q_valid !== 1'b0) begin
         errors++;
         $display("FAIL valid_strobe: q_valid=%b, expected 0", q_valid);
      end
   endtask

   task automatic test_write_read;
      do_write(6'd5, 8'hA5);
      do_read(6'd5);
      vectors++;
      if (q_valid !== 1'b1 || q !== 8'hA5 || parity_err !== 1'b0) begin
         errors++;
         $display("FAIL write_read: q=%h q_valid=%b perr=%b, expected A5 1 0", q, q_valid, parity_err);
      end
      repeat (3) @(negedge clock);
      vectors++;
      if (q_valid !== 1'b0 || q !== 8'hA5) begin
         errors++;
         $display("FAIL q_hold: q=%h q_valid=%b, expected A5 0", q, q_valid);
      end
   endtask

   task automatic test_rdw;
      we = 1'b1; write_addr = 6'd9; data = 8'h3C;
      re = 1'b1; read_addr = 6'd9;
      @(negedge clock);
      we = 1'b0; re = 1'b0;
      repeat (LAT - 1) @(negedge clock);
      vectors++;
      if (q_valid !== 1'b1 || q !== 8'h3C) begin
         errors++;
         $display("FAIL write_first: q=%h q_valid=%b, expected 3C 1", q, q_valid);
      end
      // A write to one address must not disturb a read of another in the same cycle
      we = 1'b1; write_addr = 6'd10; data = 8'h55;
      re = 1'b1; read_addr = 6'd5;
      @(negedge clock);
      we = 1'b0; re = 1'b0;
      repeat (LAT - 1) @(negedge clock);
      vectors++;
      if (q_valid !== 1'b1 || q !== 8'hA5) begin
         errors++;
         $display("FAIL diff_addr: q=%h q_valid=%b, expected A5 1", q, q_valid);
      end
      do_read(6'd10);
      vectors++;
      if (q_valid !== 1'b1 || q !== 8'h55) begin
         errors++;
         $display("FAIL diff_addr_wr: q=%h, expected 55", q);
      end
   endtask

   task automatic test_back_to_back;
      int bad = 0;
      logic [7:0] exp;
      for (int i = 0; i < 8; i++) do_write(6'(20 + i), 8'(8'h11 * i + 8'h03));
      for (int i = 0; i < 8 + LAT; i++) begin
         if (i >= LAT) begin
            exp = 8'(8'h11 * (i - LAT) + 8'h03);
            if (q_valid !== 1'b1 || q !== exp) bad++;
         end
         if (i < 8) begin
            re = 1'b1; read_addr = 6'(20 + i);
         end else begin
            re = 1'b0;
         end
         @(negedge clock);
      end
      vectors++;
      if (bad != 0) begin
         errors++;
         $display("FAIL back_to_back: %0d bad reads, expected 0", bad);
      end
   endtask

   task automatic test_reset_mid_clear;
      int cnt;
      do_write(6'd7, 8'hFF);
      do_read(6'd7);
      vectors++;
      if (q !== 8'hFF || q_valid !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_write: q=%h q_valid=%b, expected FF 1", q, q_valid);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      repeat (20) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      wait_clear(cnt);
      vectors++;
      if (cnt != 64) begin
         errors++;
         $display("FAIL restart_busy_length: got %0d cycles, expected 64", cnt);
      end
      do_read(6'd7);
      vectors++;
      if (q !== 8'h00 || q_valid !== 1'b1) begin
         errors++;
         $display("FAIL recleared_addr7: q=%h q_valid=%b, expected 00 1", q, q_valid);
      end
   endtask

   task automatic test_busy_ignore;
      int cnt = 0;
      int seen_valid = 0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      while (busy === 1'b1 && cnt < 200) begin
         if (q_valid !== 1'b0) seen_valid++;
         if (cnt >= 5 && cnt < 15) begin
            we = 1'b1; write_addr = 6'd3; data = 8'h77;
            re = 1'b1; read_addr = 6'd3;
         end else begin
            we = 1'b0; re = 1'b0;
         end
         @(negedge clock);
         cnt++;
      end
      we = 1'b0; re = 1'b0;
      vectors++;
      if (seen_valid != 0 || cnt != 64 || q_valid !== 1'b0) begin
         errors++;
         $display("FAIL busy_ignore: valid_seen=%0d busy_cycles=%0d q_valid=%b, expected 0 64 0",
                  seen_valid, cnt, q_valid);
      end
      do_read(6'd3);
      vectors++;
      if (q !== 8'h00 || q_valid !== 1'b1) begin
         errors++;
         $display("FAIL busy_write_dropped: q=%h q_valid=%b, expected 00 1", q, q_valid);
      end
   endtask

`ifdef RAM_PARITY_EN
   task automatic test_parity;
      dut.mem[12][0] = ~dut.mem[12][0];
      do_read(6'd12);
      vectors++;
      if (q_valid !== 1'b1 || q !== 8'h01 || parity_err !== 1'b1) begin
         errors++;
         $display("FAIL parity_detect: q=%h q_valid=%b perr=%b, expected 01 1 1", q, q_valid, parity_err);
      end
      @(negedge clock);
      vectors++;
      if (parity_err !== 1'b0) begin
         errors++;
         $display("FAIL parity_idle: perr=%b, expected 0", parity_err);
      end
      do_read(6'd13);
      vectors++;
      if (q_valid !== 1'b1 || parity_err !== 1'b0) begin
         errors++;
         $display("FAIL parity_clean: q_valid=%b perr=%b, expected 1 0", q_valid, parity_err);
      end
   endtask
`endif

   initial begin
      @(negedge clock);
      test_reset();
      test_clear_readback();
      test_write_read();
      test_rdw();
      test_back_to_back();
      test_reset_mid_clear();
      test_busy_ignore();
`ifdef RAM_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
